// File: rtl/udp_oe_pkg.sv
// Shared UDP offload engine definitions: ARP constants and the reply beat former.
// arp_beat() maps a beat index plus the snapshotted addresses onto one 64-bit word.
package udp_oe_pkg;

  localparam logic [15:0] ETHERTYPE_ARP   = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPv4  = 16'h0800;
  localparam logic [7:0]  ARP_HLEN        = 8'h06;
  localparam logic [7:0]  ARP_PLEN        = 8'h04;
  localparam logic [15:0] ARP_OPER_REPLY  = 16'h0002;
  localparam int          ARP_FRAME_BEATS = 8;
  localparam int          ARP_BEAT_W      = $clog2(ARP_FRAME_BEATS);

  typedef enum logic {ST_IDLE, ST_SEND} arp_state_e;

  typedef struct packed {
    logic [47:0] fpga_mac;
    logic [31:0] fpga_ip;
    logic [47:0] host_mac;
    logic [31:0] host_ip;
  } arp_fields_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } arp_beat_t;

  function automatic arp_beat_t arp_beat(input logic [ARP_BEAT_W-1:0] beat,
                                         input arp_fields_t f, input logic pad);
    arp_beat_t b;
    b.data = '0;
    b.keep = 8'hFF;
    b.last = 1'b0;
    case (beat)
      3'd0: b.data = {f.host_mac, f.fpga_mac[47:32]};
      3'd1: b.data = {f.fpga_mac[31:0], ETHERTYPE_ARP, ARP_HTYPE_ETH};
      3'd2: b.data = {ARP_PTYPE_IPv4, ARP_HLEN, ARP_PLEN, ARP_OPER_REPLY, f.fpga_mac[47:32]};
      3'd3: b.data = {f.fpga_mac[31:0], f.fpga_ip};
      3'd4: b.data = {f.host_mac, f.host_ip[31:16]};
      3'd5: begin
        b.data = {f.host_ip[15:0], 48'h0};
        // Unpadded frame ends after the two target-IP bytes.
        if (!pad) begin
          b.keep = 8'hC0;
          b.last = 1'b1;
        end
      end
      3'd7: begin
        b.keep = 8'hF0;
        b.last = 1'b1;
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/arp_reply_tx_if.sv
// 64-bit AXI-S link from the ARP reply generator to the TX arbiter.
interface arp_reply_tx_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/arp_reply_tx.sv
// ARP reply frame generator: one-deep request queue, registered AXI-S output,
// reply/drop counters for status CSRs.
module arp_reply_tx
  import udp_oe_pkg::*;
#(
  parameter bit PAD_TO_MIN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arp_trigger,
  input  logic [47:0]           fpga_mac_adr,
  input  logic [31:0]           fpga_ip_adr,
  input  logic [47:0]           host_mac_adr,
  input  logic [31:0]           host_ip_adr,
  arp_reply_tx_if.master        arp_tx,
  output logic                  busy,
  output logic [15:0]           reply_count,
  output logic [15:0]           drop_count
);

  arp_state_e              state, state_next;
  logic [ARP_BEAT_W-1:0]   beat;
  arp_fields_t             fields, live;
  arp_beat_t               out_q, beat_src;
  logic                    tvalid_q, pending, pending_next, drop;
  logic                    start, accept, done;

  assign live = {fpga_mac_adr, fpga_ip_adr, host_mac_adr, host_ip_adr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_SEND;
      ST_SEND: if (done)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    start    = (state == ST_IDLE) && (arp_trigger || pending);
    accept   = (state == ST_SEND) && tvalid_q && arp_tx.tready;
    done     = accept && out_q.last;
    beat_src = start ? arp_beat('0, live, PAD_TO_MIN)
                     : arp_beat(beat + 1'b1, fields, PAD_TO_MIN);
    pending_next = pending;
    drop         = 1'b0;
    // Starting a pending request frees the slot for a trigger in the same cycle.
    if (state == ST_IDLE) begin
      if (pending) pending_next = arp_trigger;
    end else if (arp_trigger) begin
      if (pending) drop = 1'b1;
      else         pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fields      <= '0;
      beat        <= '0;
      out_q       <= '0;
      tvalid_q    <= 1'b0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      reply_count <= '0;
      drop_count  <= '0;
    end else begin
      pending <= pending_next;
      busy    <= (state_next == ST_SEND) || pending_next;
      if (drop) drop_count <= drop_count + 16'd1;
      if (start) begin
        fields   <= live;
        beat     <= '0;
        out_q    <= beat_src;
        tvalid_q <= 1'b1;
      end else if (done) begin
        out_q       <= '0;
        tvalid_q    <= 1'b0;
        reply_count <= reply_count + 16'd1;
      end else if (accept) begin
        beat  <= beat + 1'b1;
        out_q <= beat_src;
      end
    end
  end

  assign arp_tx.tvalid = tvalid_q;
  assign arp_tx.tdata  = out_q.data;
  assign arp_tx.tkeep  = out_q.keep;
  assign arp_tx.tlast  = out_q.last;

endmodule

// File: tb/tb_arp_reply_tx.sv
// Scoreboard bench for arp_reply_tx: padded and unpadded instances.
module tb_arp_reply_tx;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig1 = 1'b0, trig0 = 1'b0;
  logic [47:0] fm, hm;
  logic [31:0] fi, hi;
  logic busy1, busy0;
  logic [15:0] reply1, drop1, reply0, drop0;

  exp_t q1[$], q0[$];
  exp_t e1, e0;
  int n_chk = 0, n_pass = 0, cyc = 0, last_tlast_cyc = 0;
  bit toggle_en = 1'b0, stalled = 1'b0;
  logic [63:0] held_data;
  logic [7:0]  held_keep;
  logic        held_last;

  arp_reply_tx_if tif1();
  arp_reply_tx_if tif0();

  arp_reply_tx #(.PAD_TO_MIN(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .arp_trigger(trig1),
    .fpga_mac_adr(fm), .fpga_ip_adr(fi), .host_mac_adr(hm), .host_ip_adr(hi),
    .arp_tx(tif1), .busy(busy1), .reply_count(reply1), .drop_count(drop1));

  arp_reply_tx #(.PAD_TO_MIN(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .arp_trigger(trig0),
    .fpga_mac_adr(fm), .fpga_ip_adr(fi), .host_mac_adr(hm), .host_ip_adr(hi),
    .arp_tx(tif0), .busy(busy0), .reply_count(reply0), .drop_count(drop0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (toggle_en) tif1.tready = ~tif1.tready;
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse1();
    trig1 = 1'b1;
    tick(1);
    trig1 = 1'b0;
  endtask

  task automatic set_fields(input logic [47:0] f_mac, input logic [31:0] f_ip,
                            input logic [47:0] h_mac, input logic [31:0] h_ip);
    fm = f_mac; fi = f_ip; hm = h_mac; hi = h_ip;
  endtask

  // Builds the frame byte-by-byte in wire order, then slices it into beats.
  task automatic push_model(input bit to0, input bit pad, input int gap0);
    logic [7:0] b [64];
    int nbytes, nbeats;
    exp_t e;
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      b[i]      = hm[47-8*i -: 8];
      b[6+i]    = fm[47-8*i -: 8];
      b[22+i]   = fm[47-8*i -: 8];
      b[32+i]   = hm[47-8*i -: 8];
    end
    b[12] = 8'h08; b[13] = 8'h06; b[14] = 8'h00; b[15] = 8'h01;
    b[16] = 8'h08; b[17] = 8'h00; b[18] = 8'h06; b[19] = 8'h04;
    b[20] = 8'h00; b[21] = 8'h02;
    for (int i = 0; i < 4; i++) begin
      b[28+i] = fi[31-8*i -: 8];
      b[38+i] = hi[31-8*i -: 8];
    end
    nbytes = pad ? 60 : 42;
    nbeats = (nbytes + 7) / 8;
    for (int j = 0; j < nbeats; j++) begin
      for (int m = 0; m < 8; m++) begin
        e.data[63-8*m -: 8] = b[8*j+m];
        e.keep[7-m]         = (8*j + m) < nbytes;
      end
      e.last = (j == nbeats - 1);
      e.gap  = (j == 0) ? gap0 : 0;
      if (to0) q0.push_back(e);
      else     q1.push_back(e);
    end
  endtask

  task automatic push_hand();
    logic [63:0] d [8];
    exp_t e;
    d[0] = 64'hA0B0C0D0E0F00011; d[1] = 64'h2233445508060001;
    d[2] = 64'h0800060400020011; d[3] = 64'h22334455C0A80102;
    d[4] = 64'hA0B0C0D0E0F0C0A8; d[5] = 64'h0101000000000000;
    d[6] = 64'h0;                d[7] = 64'h0;
    for (int j = 0; j < 8; j++) begin
      e.data = d[j];
      e.keep = (j == 7) ? 8'hF0 : 8'hFF;
      e.last = (j == 7);
      e.gap  = 0;
      q1.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (q1.size() == 0 && q0.size() == 0) break;
      tick(1);
    end
    chk("drain_timeout", 64'(q1.size() + q0.size()), 64'd0);
    tick(2);
  endtask

  always @(negedge clk) begin
    if (!rst_n) stalled = 1'b0;
    else if (tif1.tvalid) begin
      if (stalled) begin
        chk("stall_hold_data", tif1.tdata, held_data);
        chk("stall_hold_keep", 64'(tif1.tkeep), 64'(held_keep));
        chk("stall_hold_last", 64'(tif1.tlast), 64'(held_last));
      end
      if (tif1.tready) begin
        stalled = 1'b0;
        chk("beat_available", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          chk("beat_data", tif1.tdata, e1.data);
          chk("beat_keep", 64'(tif1.tkeep), 64'(e1.keep));
          chk("beat_last", 64'(tif1.tlast), 64'(e1.last));
          if (e1.gap != 0) chk("frame_gap", 64'(cyc - last_tlast_cyc), 64'(e1.gap));
          if (tif1.tlast) last_tlast_cyc = cyc;
        end
      end else begin
        stalled   = 1'b1;
        held_data = tif1.tdata;
        held_keep = tif1.tkeep;
        held_last = tif1.tlast;
      end
    end else begin
      if (stalled) chk("valid_held_while_stalled", 64'(tif1.tvalid), 64'd1);
      stalled = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && tif0.tvalid && tif0.tready) begin
      chk("pad0_beat_available", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("pad0_beat_data", tif0.tdata, e0.data);
        chk("pad0_beat_keep", 64'(tif0.tkeep), 64'(e0.keep));
        chk("pad0_beat_last", 64'(tif0.tlast), 64'(e0.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tif1.tready = 1'b1;
    tif0.tready = 1'b1;
    set_fields(48'h001122334455, 32'hC0A80102, 48'hA0B0C0D0E0F0, 32'hC0A80101);
    tick(2);
    chk("rst_tvalid", 64'(tif1.tvalid), 64'd0);
    chk("rst_tlast",  64'(tif1.tlast), 64'd0);
    chk("rst_tdata",  tif1.tdata, 64'd0);
    chk("rst_tkeep",  64'(tif1.tkeep), 64'd0);
    chk("rst_busy",   64'(busy1), 64'd0);
    chk("rst_counts", {32'd0, reply1, drop1}, 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Single frame, always ready; beat 0 must follow the trigger edge directly.
    push_hand();
    pulse1();
    chk("latency_tvalid", 64'(tif1.tvalid), 64'd1);
    chk("busy_in_frame", 64'(busy1), 64'd1);
    drain();
    chk("reply_after_1", 64'(reply1), 64'd1);
    chk("busy_after_1", 64'(busy1), 64'd0);

    // Ready toggling every cycle.
    toggle_en = 1'b1;
    push_hand();
    pulse1();
    drain();
    toggle_en = 1'b0;
    tif1.tready = 1'b1;
    chk("reply_after_2", 64'(reply1), 64'd2);

    // Second trigger mid-frame, with inputs changing after the snapshot.
    set_fields(48'h02AABBCCDDEE, 32'h0A000001, 48'h0E1234567890, 32'h0A0000FE);
    push_model(1'b0, 1'b1, 0);
    pulse1();
    set_fields(48'h0266778899AA, 32'hAC100005, 48'h0E0102030405, 32'hAC100009);
    push_model(1'b0, 1'b1, 2);
    tick(3);
    pulse1();
    drain();
    chk("reply_after_3", 64'(reply1), 64'd4);
    chk("drop_after_3", 64'(drop1), 64'd0);

    // Three triggers in one frame: one queued, one dropped.
    push_model(1'b0, 1'b1, 0);
    push_model(1'b0, 1'b1, 2);
    pulse1();
    tick(1);
    pulse1();
    tick(1);
    pulse1();
    chk("busy_pending", 64'(busy1), 64'd1);
    drain();
    chk("reply_after_4", 64'(reply1), 64'd6);
    chk("drop_after_4", 64'(drop1), 64'd1);

    // Asynchronous reset while beat 4 is presented.
    push_model(1'b0, 1'b1, 0);
    pulse1();
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", 64'(tif1.tvalid), 64'd0);
    chk("async_rst_busy", 64'(busy1), 64'd0);
    q1.delete();
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("post_rst_tvalid", 64'(tif1.tvalid), 64'd0);
    chk("post_rst_counts", {32'd0, reply1, drop1}, 64'd0);

    // Unpadded instance: 6 beats ending with the target IP bytes.
    set_fields(48'h001122334455, 32'hC0A80102, 48'hA0B0C0D0E0F0, 32'hC0A80101);
    push_model(1'b1, 1'b0, 0);
    trig0 = 1'b1;
    tick(1);
    trig0 = 1'b0;
    chk("pad0_latency_tvalid", 64'(tif0.tvalid), 64'd1);
    drain();
    chk("pad0_reply", 64'(reply0), 64'd1);
    chk("pad0_busy", 64'(busy0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/arp_reply_tx.md
# arp_reply_tx

- Generates a complete ARP reply frame whenever the UDP offload engine RX path pulses `arp_trigger`.
- Sits directly downstream of the RX decoder's `arp_trigger` output, in the Ethernet clock domain.
- Drives a 64-bit AXI-S stream into the TX-path arbiter that shares the HSSI TX port with UDP traffic.
- Keeps a one-deep pending request plus reply and drop counters for the `udp_oe` status CSRs.

## Interface
Parameters:
- `PAD_TO_MIN`, 1: pad the frame to 60 bytes (8 beats); 0 stops at 42 bytes (6 beats).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  Ethernet clock (same clock as `eth_rx_axis.clk`)
- `rst_n`  in  1  asynchronous, active-low reset
- `arp_trigger`  in  1  single-cycle request from the RX decoder
- `fpga_mac_adr`  in  48  FPGA MAC; sender hardware address and source address
- `fpga_ip_adr`  in  32  FPGA IPv4; sender protocol address
- `host_mac_adr`  in  48  host MAC; destination address and target hardware address
- `host_ip_adr`  in  32  host IPv4; target protocol address
- `arp_tx_tvalid`  out  1  AXI-S valid
- `arp_tx_tready`  in  1  AXI-S ready from the TX arbiter
- `arp_tx_tdata`  out  64  beat data; first wire byte in [63:56]
- `arp_tx_tkeep`  out  8  byte enables; `tkeep[7]` qualifies [63:56]
- `arp_tx_tlast`  out  1  last beat of the frame
- `busy`  out  1  frame in flight or request pending (arbiter hint)
- `reply_count`  out  16  frames completed, wraps modulo 2^16
- `drop_count`  out  16  triggers discarded, wraps modulo 2^16

## Operation
FSM states:
- `IDLE`: a trigger or a pending request moves to `SEND`. On entry, fields are snapshotted, `beat` is set to 0 and `pending` is cleared.
- `SEND`: beat `beat` is presented. On `tvalid & tready`, `beat` increments. The beat carrying `tlast` returns to `IDLE` and increments `reply_count`.

Beat layout (big-endian within the word):
- 0: host MAC[47:0], fpga MAC[47:32]
- 1: fpga MAC[31:0], 0x0806, HTYPE 0x0001
- 2: PTYPE 0x0800, HLEN 0x06, PLEN 0x04, OPER 0x0002, fpga MAC[47:32]
- 3: fpga MAC[31:0], fpga IP[31:0]
- 4: host MAC[47:0], host IP[31:16]
- 5: host IP[15:0], 48 zero bits
  - `PAD_TO_MIN=0`: `tlast=1`, `tkeep=0xC0`
  - `PAD_TO_MIN=1`: `tkeep=0xFF`
- 6: all zero, `tkeep=0xFF`
- 7: all zero, `tkeep=0xF0`, `tlast=1`
- All other beats have `tkeep=0xFF`.

Trigger handling:
- A trigger during `SEND`, or during the `IDLE` cycle that starts a pending request, sets `pending`.
- A trigger while `pending` is already set increments `drop_count`; `pending` stays 1.
- Snapshotted fields are stable for the whole frame; input changes mid-frame affect only the next frame.

## Timing
- Reset values: `arp_tx_tvalid`, `arp_tx_tlast`, `busy` = 0; `arp_tx_tdata`, `arp_tx_tkeep` = 0; both counters = 0; FSM in `IDLE`; `pending` = 0.
- Latency: a trigger sampled at edge N puts beat 0 on the outputs (`tvalid=1`) after edge N. Best case the frame completes in 8 cycles (`PAD_TO_MIN=1`).
- AXI-S rules:
  - Once `tvalid=1`, it stays high and `tdata`/`tkeep`/`tlast` stay constant until `tready` is sampled high.
  - `tvalid` never depends combinationally on `tready`.
- Back-to-back frames: with `pending` set at `tlast` acceptance, the next beat 0 appears 2 cycles after the `tlast` handshake (one `IDLE` cycle).
- `busy = (state == SEND) | pending`, registered.
- A trigger in the same cycle as the `tlast` handshake sets `pending`; it is not dropped.
- Reset mid-frame:
  - Outputs clear asynchronously and the frame is truncated without `tlast`.
  - The downstream arbiter shares this reset and discards the partial frame.

## Structure
- Add to `udp_oe_pkg`: `ETHERTYPE_ARP` (if not already present), `ARP_HTYPE_ETH=16'h0001`, `ARP_PTYPE_IPv4=16'h0800`, `ARP_HLEN=8'h06`, `ARP_PLEN=8'h04`, `ARP_OPER_REPLY=16'h0002`, `ARP_FRAME_BEATS=8`.
- No sub-module. Beat formation is a combinational function `arp_beat(beat, fields)` in `udp_oe_pkg`, registered at the output.
- Counters are mapped into `udp_oe_channel_if` RX/TX status by the parent, with the same clock-domain-crossing constraint handling as the existing status buses.

## Test plan
- Single trigger, `tready=1`, fpga MAC 0x001122334455, IP 0xC0A80102, host MAC 0xA0B0C0D0E0F0, IP 0xC0A80101 -> 8 beats on consecutive cycles:
  - beat 0 = 0xA0B0C0D0E0F00011, beat 1 = 0x2233445508060001, beat 3 = 0x22334455C0A80102
  - beat 7 has `tkeep=0xF0`, `tlast=1`
  - `reply_count=1`
- `tready` toggling 1/0 every cycle -> `tdata` stable while stalled; 8 handshakes; frame identical to the first scenario.
- Trigger at beat 3 of an active frame -> second frame begins 2 cycles after the first `tlast` handshake; `reply_count=2`, `drop_count=0`.
- Three triggers during one frame -> exactly 2 frames sent; `drop_count=1`.
- `rst_n` asserted at beat 4 -> `tvalid` drops immediately; after release, no output without a new trigger; counters read 0.
- `PAD_TO_MIN=0` -> 6 beats; beat 5 has `tkeep=0xC0`, `tlast=1`, data = 0x0101000000000000.
